// File: rtl/seg_pkg.sv
// Shared constants and helpers for the seven-segment scan driver.
package seg_pkg;

  // Active-low glyphs with dp off: nibble F in the top byte down to nibble 0 in the bottom byte.
  localparam logic [127:0] FONT_TABLE = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  localparam int DP_BIT = 7;

  function automatic logic apply_pol(input logic active_low_bit, input bit active_low);
    return active_low ? active_low_bit : ~active_low_bit;
  endfunction

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seg_font_rom.sv
// Hex nibble plus decimal point to an active-low segment pattern.
module seg_font_rom
  import seg_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       dp_i,
  output logic [7:0] pattern_o
);

  always_comb begin
    pattern_o = FONT_TABLE[{nibble_i, 3'b000} +: 8];
    if (dp_i) pattern_o[DP_BIT] = 1'b0;
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed seven-segment driver: slot/digit/blink counters, double-buffered
// display bank, blanking and PWM, registered anode and segment outputs.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 8,
  parameter int REFRESH_DIV = 250000,
  parameter int BLINK_DIV   = 64,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic                    lz_suppress,
  input  logic [3:0]              brightness,
  output logic [7:0]              seg_data,
  output logic [NUM_DIGITS-1:0]   seg_an,
  output logic                    frame_done
);

  localparam int IW     = idx_w(NUM_DIGITS);
  localparam int CW     = idx_w(REFRESH_DIV);
  localparam int FW     = idx_w(BLINK_DIV);
  localparam int SLICE  = REFRESH_DIV / 16;
  localparam int BANK_W = 7 * NUM_DIGITS + 5;
  localparam logic [7:0]            SEG_OFF = {8{ACTIVE_LOW}};
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{ACTIVE_LOW}};

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [FW-1:0]         fcnt_q, fcnt_d;
  logic                  blink_phase_q, blink_phase_d;
  logic [BANK_W-1:0]     pend_q, pend_d, act_q, act_d, bank_in;
  logic [7:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  frame_done_q;
  logic                  slot_end, wrap;

  assign bank_in  = {brightness, lz_suppress, blink_mask, dp_in, digit_en, data_in};
  assign slot_end = (cnt_q == CW'(REFRESH_DIV - 1));
  assign wrap     = slot_end && (idx_q == IW'(NUM_DIGITS - 1));

  always_comb begin
    cnt_d         = slot_end ? '0 : cnt_q + CW'(1);
    idx_d         = idx_q;
    fcnt_d        = fcnt_q;
    blink_phase_d = blink_phase_q;
    if (slot_end) idx_d = wrap ? '0 : idx_q + IW'(1);
    if (wrap) begin
      if (fcnt_q == FW'(BLINK_DIV - 1)) begin
        fcnt_d        = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        fcnt_d = fcnt_q + FW'(1);
      end
    end
    pend_d = load ? bank_in : pend_q;
    // Taking pend_d rather than pend_q lets a load on the wrap cycle land in this frame.
    act_d  = wrap ? pend_d : act_q;
  end

  logic [4*NUM_DIGITS-1:0] act_data;
  logic [NUM_DIGITS-1:0]   act_en, act_dp, act_blink;
  logic                    act_lz;
  logic [3:0]              act_br;

  assign {act_br, act_lz, act_blink, act_dp, act_en, act_data} = act_q;

  // zero_run[i]: every digit from i upward is zero or disabled.
  logic [NUM_DIGITS:1]   zero_run;
  logic [NUM_DIGITS-1:0] suppressed;

  assign zero_run[NUM_DIGITS] = 1'b1;
  assign suppressed[0]        = 1'b0;

  genvar gi;
  for (gi = 1; gi < NUM_DIGITS; gi++) begin : g_lz
    assign zero_run[gi]   = zero_run[gi+1] && ((act_data[4*gi +: 4] == 4'd0) || !act_en[gi]);
    assign suppressed[gi] = act_lz && zero_run[gi];
  end

  logic [3:0]            cur_nib;
  logic                  cur_blank, cur_lit;
  logic [31:0]           pwm_limit;
  logic [7:0]            font_pat, seg_raw;
  logic [NUM_DIGITS-1:0] an_raw;

  assign cur_nib   = act_data[{idx_q, 2'b00} +: 4];
  assign cur_blank = !act_en[idx_q] || (act_blink[idx_q] && blink_phase_q) || suppressed[idx_q];
  assign pwm_limit = (32'(act_br) + 32'd1) * 32'(SLICE);
  assign cur_lit   = !cur_blank && (32'(cnt_q) < pwm_limit);

  seg_font_rom u_font (
    .nibble_i  (cur_nib),
    .dp_i      (act_dp[idx_q]),
    .pattern_o (font_pat)
  );

  assign seg_raw = cur_lit ? font_pat : 8'hFF;

  for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_an
    assign an_raw[gi] = !(cur_lit && (idx_q == IW'(gi)));
    assign an_d[gi]   = apply_pol(an_raw[gi], ACTIVE_LOW);
  end

  for (gi = 0; gi < 8; gi++) begin : g_seg
    assign seg_d[gi] = apply_pol(seg_raw[gi], ACTIVE_LOW);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q         <= '0;
      idx_q         <= '0;
      fcnt_q        <= '0;
      blink_phase_q <= 1'b0;
      pend_q        <= '0;
      act_q         <= '0;
      seg_q         <= SEG_OFF;
      an_q          <= AN_OFF;
      frame_done_q  <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      fcnt_q        <= fcnt_d;
      blink_phase_q <= blink_phase_d;
      pend_q        <= pend_d;
      act_q         <= act_d;
      seg_q         <= seg_d;
      an_q          <= an_d;
      frame_done_q  <= wrap;
    end
  end

  assign seg_data   = seg_q;
  assign seg_an     = an_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: frame-level reference model checked every cycle,
// plus pinned expectations for the directed scenarios and randomized loads.
module tb_seg_scan_driver;

  localparam int N     = 8;
  localparam int RD    = 16;
  localparam int BD    = 2;
  localparam int FRAME = N * RD;

  typedef struct {
    logic [31:0] data;
    logic [7:0]  en;
    logic [7:0]  dp;
    logic [7:0]  blink;
    logic        lz;
    logic [3:0]  br;
  } bank_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [31:0] data_in = '0;
  logic [7:0]  digit_en = '0, dp_in = '0, blink_mask = '0;
  logic        lz_suppress = 1'b0;
  logic [3:0]  brightness = '0;
  logic [7:0]  seg_data, seg_an;
  logic        frame_done;

  int n_cmp = 0;
  int n_bad = 0;
  int k = 0;  // index of the scan state whose outputs appear after the next edge
  bank_t pend_m, act_m;
  logic [7:0] exp_seg, exp_an;
  logic       exp_fd;
  logic [7:0] font [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                            8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  seg_scan_driver #(
    .NUM_DIGITS  (N),
    .REFRESH_DIV (RD),
    .BLINK_DIV   (BD),
    .ACTIVE_LOW  (1'b1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .data_in     (data_in),
    .digit_en    (digit_en),
    .dp_in       (dp_in),
    .blink_mask  (blink_mask),
    .lz_suppress (lz_suppress),
    .brightness  (brightness),
    .seg_data    (seg_data),
    .seg_an      (seg_an),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] want, input int st);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s state=%0d got=%02h want=%02h", name, st, got, want);
    end
  endtask

  function automatic bank_t zero_bank();
    bank_t b;
    b.data = '0; b.en = '0; b.dp = '0; b.blink = '0; b.lz = 1'b0; b.br = '0;
    return b;
  endfunction

  // What the display must show for scan state kk, given the bank active in that frame.
  function automatic void model_out(input bank_t b, input int kk, output logic [7:0] es, output logic [7:0] ea);
    int cnt, idx, top;
    bit phase, supp, lit;
    logic [3:0] nib;
    cnt   = kk % RD;
    idx   = (kk / RD) % N;
    phase = ((kk / FRAME / BD) % 2) == 1;
    top   = -1;
    for (int j = N - 1; j >= 0; j--)
      if (top < 0 && b.en[j] && b.data[4*j +: 4] != 4'd0) top = j;
    supp = b.lz && idx > 0 && idx > top;
    lit  = b.en[idx] && !(b.blink[idx] && phase) && !supp && (cnt < (int'(b.br) + 1) * (RD / 16));
    nib  = b.data[4*idx +: 4];
    es   = lit ? (font[nib] & (b.dp[idx] ? 8'h7F : 8'hFF)) : 8'hFF;
    ea   = lit ? ~(8'h01 << idx) : 8'hFF;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      k      = 0;
      pend_m = zero_bank();
      act_m  = zero_bank();
    end else begin
      if (k % FRAME == 0) act_m = pend_m;
      if (load) pend_m = '{data_in, digit_en, dp_in, blink_mask, lz_suppress, brightness};
      model_out(act_m, k, exp_seg, exp_an);
      exp_fd = (k % FRAME == FRAME - 1);
      k++;
      #1;
      check("seg_data", seg_data, exp_seg, k - 1);
      check("seg_an", seg_an, exp_an, k - 1);
      check("frame_done", {7'd0, frame_done}, {7'd0, exp_fd}, k - 1);
    end
  end

  task automatic wait_k(input int target);
    int guard;
    guard = 0;
    while (k != target && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    if (k != target) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_state reached=%0d want=%0d", k, target);
    end
  endtask

  task automatic do_load(input logic [31:0] d, input logic [7:0] en, input logic [7:0] dp,
                         input logic [7:0] bl, input logic lz, input logic [3:0] br);
    data_in = d; digit_en = en; dp_in = dp; blink_mask = bl; lz_suppress = lz; brightness = br;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic chk(input int s, input logic [7:0] seg, input logic [7:0] an);
    wait_k(s + 1);
    check("pin_seg", seg_data, seg, s);
    check("pin_an", seg_an, an, s);
  endtask

  task automatic chk_fd(input int s, input logic v);
    wait_k(s + 1);
    check("pin_frame_done", {7'd0, frame_done}, {7'd0, v}, s);
  endtask

  initial begin
    int base;
    repeat (3) @(negedge clk);
    check("reset_seg", seg_data, 8'hFF, -1);
    check("reset_an", seg_an, 8'hFF, -1);
    check("reset_fd", {7'd0, frame_done}, 8'h00, -1);
    rst = 1'b0;

    // Counting pattern at full brightness.
    do_load(32'h76543210, 8'hFF, 8'h00, 8'h00, 1'b0, 4'd15);
    chk(160, 8'hA4, 8'hFB);
    chk(240, 8'hF8, 8'h7F);
    chk_fd(254, 1'b0);
    chk_fd(255, 1'b1);

    // Leading-zero suppression.
    wait_k(300);
    do_load(32'h00000F05, 8'hFF, 8'h00, 8'h00, 1'b1, 4'd15);
    chk(384, 8'h92, 8'hFE);
    chk(400, 8'hC0, 8'hFD);
    chk(416, 8'h8E, 8'hFB);

    // Mid-frame load at idx 3 must not show until the wrap.
    wait_k(437);
    do_load(32'h89ABCDEF, 8'hFF, 8'h00, 8'h00, 1'b0, 4'd15);
    chk(464, 8'hFF, 8'hFF);
    chk(511, 8'hFF, 8'hFF);
    chk(512, 8'h8E, 8'hFE);

    // Blink on digit 0 only.
    wait_k(600);
    do_load(32'h76543210, 8'hFF, 8'h00, 8'h01, 1'b0, 4'd15);
    chk(640, 8'hC0, 8'hFE);
    chk(656, 8'hF9, 8'hFD);
    chk(768, 8'hFF, 8'hFF);
    chk(784, 8'hF9, 8'hFD);
    chk(896, 8'hFF, 8'hFF);
    chk(1024, 8'hC0, 8'hFE);

    // Load on the wrap cycle itself, reduced brightness and a dp.
    wait_k(1151);
    do_load(32'h76543210, 8'hFF, 8'h02, 8'h00, 1'b0, 4'd3);
    chk(1152, 8'hC0, 8'hFE);
    chk(1171, 8'h79, 8'hFD);
    chk(1172, 8'hFF, 8'hFF);

    for (int i = 0; i < 25; i++) begin
      repeat ($urandom_range(1, 200)) @(negedge clk);
      if ($urandom_range(0, 2) == 0) wait_k((k / FRAME + 1) * FRAME - 1);
      do_load($urandom & (($urandom_range(0, 1) == 1) ? 32'h00000FFF : 32'hFFFFFFFF),
              8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 4'($urandom));
    end

    // Asynchronous reset in the middle of a lit slot.
    do_load(32'h12345678, 8'hFF, 8'h00, 8'h00, 1'b0, 4'd15);
    base = (k / FRAME + 2) * FRAME;
    chk(base + 5, 8'h80, 8'hFE);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_seg", seg_data, 8'hFF, base + 6);
    check("async_rst_an", seg_an, 8'hFF, base + 6);
    check("async_rst_fd", {7'd0, frame_done}, 8'h00, base + 6);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk(2, 8'hFF, 8'hFF);
    chk(130, 8'hFF, 8'hFF);
    wait_k(200);
    do_load(32'h0000ABCD, 8'hFF, 8'h00, 8'h00, 1'b1, 4'd15);
    chk(256, 8'hA1, 8'hFE);
    chk(336, 8'hFF, 8'hFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
